// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter with busy scoreboard and zero-fill sweep
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_num,
  input  logic [32*NREQ-1:0] req_data,
  input  logic              issue,
  input  logic [4:0]        issue_num,
  output logic [31:0]       busy,
  output logic [4:0]        wnum,
  output logic [31:0]       wdata,
  output logic              write,
  output logic              init_done
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t INIT = CLEAR_ON_RESET ? CLEAR : RUN;
  state_t state, state_next;
  logic [4:0] cnt;
  logic [PW-1:0] ptr, sel;
  logic hit, found;
  logic [4:0] sel_num;
  logic [31:0] sel_data, busy_next;
  assign init_done = state == RUN;
  always_comb begin
    hit = 1'b0;
    sel = ptr;
    for (int i = 1; i <= NREQ; i++) begin
      if (!hit && req_valid[(int'(ptr) + i) % NREQ]) begin
        hit = 1'b1;
        sel = PW'((int'(ptr) + i) % NREQ);
      end
    end
    found = hit && state == RUN;
    sel_num = req_num[5*sel +: 5];
    sel_data = req_data[32*sel +: 32];
    req_ready = found ? NREQ'(1) << sel : '0;
    busy_next = busy;
    if (found) busy_next[sel_num] = 1'b0;
    // a same-cycle issue overrides the retire so the new writer stays tracked
    if (issue && issue_num != 5'd0) busy_next[issue_num] = 1'b1;
    state_next = (state == CLEAR && cnt == 5'd31) ? RUN : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= INIT;
    else state <= state_next;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      write <= 1'b0;
      wnum <= '0;
      wdata <= '0;
      busy <= '0;
      ptr <= PW'(NREQ - 1);
    end else if (state == CLEAR) begin
      write <= 1'b1;
      wnum <= cnt;
      wdata <= '0;
      cnt <= cnt + 5'd1;
      busy <= '0;
    end else begin
      busy <= busy_next;
      write <= found && sel_num != 5'd0;
      if (found) begin
        wnum <= sel_num;
        wdata <= sel_data;
        ptr <= sel;
      end
    end
  end
endmodule
